// File: rtl/shake_arbiter.sv
// Session-based arbiter sharing one keccak_top SHAKE core between two requesters.
// Optional busy/grant profiling counters are compiled in with SHAKE_ARB_PERF_EN.
module shake_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r0_req,
  output logic                  r0_gnt,
  input  logic                  r0_din_valid,
  output logic                  r0_din_ready,
  input  logic [DATA_WIDTH-1:0] r0_din,
  output logic                  r0_dout_valid,
  input  logic                  r0_dout_ready,
  output logic [DATA_WIDTH-1:0] r0_dout,
  input  logic                  r0_force_done,
  input  logic                  r1_req,
  output logic                  r1_gnt,
  input  logic                  r1_din_valid,
  output logic                  r1_din_ready,
  input  logic [DATA_WIDTH-1:0] r1_din,
  output logic                  r1_dout_valid,
  input  logic                  r1_dout_ready,
  output logic [DATA_WIDTH-1:0] r1_dout,
  input  logic                  r1_force_done,
  output logic                  sh_din_valid,
  input  logic                  sh_din_ready,
  output logic [DATA_WIDTH-1:0] sh_din,
  input  logic                  sh_dout_valid,
  output logic                  sh_dout_ready,
  input  logic [DATA_WIDTH-1:0] sh_dout,
  output logic                  sh_force_done,
  output logic [1:0]            state_dbg,
  output logic                  busy
`ifdef SHAKE_ARB_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0]  r0_busy_cycles,
  output logic [CNT_WIDTH-1:0]  r1_busy_cycles,
  output logic [CNT_WIDTH-1:0]  grant_count
`endif
);

  // Handshakes: a word moves on a port when its valid and ready are both high
  // at a rising clk edge; valid never waits on ready.
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, FLUSH} state_t;

  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);

  state_t        state, state_nxt;
  logic          last;
  logic [FW-1:0] flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        GRANT0: if (!r0_req) begin last <= 1'b0; flush_cnt <= '0; end
        GRANT1: if (!r1_req) begin last <= 1'b1; flush_cnt <= '0; end
        FLUSH:  flush_cnt <= flush_cnt + FW'(1);
        default: ;
      endcase
    end
  end

  // On a tie the requester that did not own the last session wins.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (r0_req && (!r1_req || last)) state_nxt = GRANT0;
        else if (r1_req)                 state_nxt = GRANT1;
      end
      GRANT0: if (!r0_req) state_nxt = FLUSH;
      GRANT1: if (!r1_req) state_nxt = FLUSH;
      FLUSH:  if (flush_cnt == FLUSH_LAST) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    r0_gnt        = 1'b0;
    r1_gnt        = 1'b0;
    r0_din_ready  = 1'b0;
    r1_din_ready  = 1'b0;
    r0_dout_valid = 1'b0;
    r1_dout_valid = 1'b0;
    sh_din_valid  = 1'b0;
    sh_din        = r0_din;
    sh_dout_ready = 1'b0;
    sh_force_done = 1'b0;
    busy          = 1'b0;
    case (state)
      GRANT0: begin
        r0_gnt        = 1'b1;
        r0_din_ready  = sh_din_ready;
        r0_dout_valid = sh_dout_valid;
        sh_din_valid  = r0_din_valid;
        sh_dout_ready = r0_dout_ready;
        sh_force_done = r0_force_done;
        busy          = 1'b1;
      end
      GRANT1: begin
        r1_gnt        = 1'b1;
        r1_din_ready  = sh_din_ready;
        r1_dout_valid = sh_dout_valid;
        sh_din_valid  = r1_din_valid;
        sh_din        = r1_din;
        sh_dout_ready = r1_dout_ready;
        sh_force_done = r1_force_done;
        busy          = 1'b1;
      end
      FLUSH: begin
        sh_force_done = 1'b1;
        busy          = 1'b1;
      end
      default: ;
    endcase
  end

  assign r0_dout   = sh_dout;
  assign r1_dout   = sh_dout;
  assign state_dbg = state;

`ifdef SHAKE_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r0_busy_cycles <= '0;
      r1_busy_cycles <= '0;
      grant_count    <= '0;
    end else begin
      if (state == GRANT0 && r0_busy_cycles != '1) r0_busy_cycles <= r0_busy_cycles + 1'b1;
      if (state == GRANT1 && r1_busy_cycles != '1) r1_busy_cycles <= r1_busy_cycles + 1'b1;
      if (state == IDLE && (state_nxt == GRANT0 || state_nxt == GRANT1))
        grant_count <= grant_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_shake_arbiter.sv
// Bench for shake_arbiter: directed scenarios plus random sessions, checked every
// cycle against a session-level reference model and a handshake word scoreboard.
module tb_shake_arbiter;
  localparam int DW = 32;
  localparam int FC = 2;
  localparam int CW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0;
  logic r0_req = 0, r0_din_valid = 0, r0_dout_ready = 0, r0_force_done = 0;
  logic r1_req = 0, r1_din_valid = 0, r1_dout_ready = 0, r1_force_done = 0;
  logic [DW-1:0] r0_din = '0, r1_din = '0, sh_dout = '0;
  logic sh_din_ready = 0, sh_dout_valid = 0;
  logic r0_gnt, r1_gnt, r0_din_ready, r1_din_ready, r0_dout_valid, r1_dout_valid;
  logic [DW-1:0] r0_dout, r1_dout, sh_din;
  logic sh_din_valid, sh_dout_ready, sh_force_done, busy;
  logic [1:0] state_dbg;
`ifdef SHAKE_ARB_PERF_EN
  logic [CW-1:0] r0_busy_cycles, r1_busy_cycles, grant_count;
`endif

  shake_arbiter #(.DATA_WIDTH(DW), .FLUSH_CYCLES(FC), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_gnt(r0_gnt), .r0_din_valid(r0_din_valid), .r0_din_ready(r0_din_ready),
    .r0_din(r0_din), .r0_dout_valid(r0_dout_valid), .r0_dout_ready(r0_dout_ready),
    .r0_dout(r0_dout), .r0_force_done(r0_force_done),
    .r1_req(r1_req), .r1_gnt(r1_gnt), .r1_din_valid(r1_din_valid), .r1_din_ready(r1_din_ready),
    .r1_din(r1_din), .r1_dout_valid(r1_dout_valid), .r1_dout_ready(r1_dout_ready),
    .r1_dout(r1_dout), .r1_force_done(r1_force_done),
    .sh_din_valid(sh_din_valid), .sh_din_ready(sh_din_ready), .sh_din(sh_din),
    .sh_dout_valid(sh_dout_valid), .sh_dout_ready(sh_dout_ready), .sh_dout(sh_dout),
    .sh_force_done(sh_force_done), .state_dbg(state_dbg), .busy(busy)
`ifdef SHAKE_ARB_PERF_EN
    , .r0_busy_cycles(r0_busy_cycles), .r1_busy_cycles(r1_busy_cycles), .grant_count(grant_count)
`endif
  );

  int n_cmp = 0;
  int n_fail = 0;
  bit started = 0;
  bit hold_core = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the core, how much flush remains, who went last.
  int m_owner = -1;
  bit m_flush = 0;
  int m_left = 0;
  bit m_last = 1;
  longint m_b0 = 0, m_b1 = 0, m_gc = 0;
  longint cnt_max = (64'd1 << CW) - 1;

  always @(posedge clk) begin
    if (rst) begin
      m_owner = -1; m_flush = 0; m_left = 0; m_last = 1;
      m_b0 = 0; m_b1 = 0; m_gc = 0;
      started = 1;
    end else if (m_flush) begin
      m_left--;
      if (m_left == 0) m_flush = 0;
    end else if (m_owner < 0) begin
      if (r0_req && (!r1_req || m_last)) m_owner = 0;
      else if (r1_req) m_owner = 1;
      if (m_owner >= 0) m_gc++;
    end else begin
      if (m_owner == 0 && m_b0 < cnt_max) m_b0++;
      if (m_owner == 1 && m_b1 < cnt_max) m_b1++;
      if (!(m_owner == 0 ? r0_req : r1_req)) begin
        m_last = (m_owner == 1);
        m_owner = -1; m_flush = 1; m_left = FC;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      logic o_valid, o_dready, o_force;
      logic [DW-1:0] o_din;
      o_valid  = (m_owner == 1) ? r1_din_valid  : r0_din_valid;
      o_dready = (m_owner == 1) ? r1_dout_ready : r0_dout_ready;
      o_force  = (m_owner == 1) ? r1_force_done : r0_force_done;
      o_din    = (m_owner == 1) ? r1_din : r0_din;
      chk("r0_gnt", r0_gnt, m_owner == 0);
      chk("r1_gnt", r1_gnt, m_owner == 1);
      chk("busy", busy, m_flush || m_owner >= 0);
      chk("sh_din_valid", sh_din_valid, m_owner >= 0 && o_valid);
      chk("sh_din", sh_din, o_din);
      chk("sh_dout_ready", sh_dout_ready, m_owner >= 0 && o_dready);
      chk("sh_force_done", sh_force_done, m_flush || (m_owner >= 0 && o_force));
      chk("r0_din_ready", r0_din_ready, m_owner == 0 && sh_din_ready);
      chk("r1_din_ready", r1_din_ready, m_owner == 1 && sh_din_ready);
      chk("r0_dout_valid", r0_dout_valid, m_owner == 0 && sh_dout_valid);
      chk("r1_dout_valid", r1_dout_valid, m_owner == 1 && sh_dout_valid);
      chk("r0_dout", r0_dout, sh_dout);
      chk("r1_dout", r1_dout, sh_dout);
`ifdef SHAKE_ARB_PERF_EN
      chk("r0_busy_cycles", r0_busy_cycles, m_b0);
      chk("r1_busy_cycles", r1_busy_cycles, m_b1);
      chk("grant_count", grant_count, m_gc);
`endif
      if (m_owner >= 0 && o_valid && sh_din_ready) exp_q.push_back(o_din);
      if (sh_din_valid && sh_din_ready) begin
        if (exp_q.size() == 0) chk("hs_unexpected", 1, 0);
        else chk("hs_word", sh_din, exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (!hold_core) begin
        sh_din_ready  = 1'($urandom_range(0, 1));
        sh_dout_valid = 1'($urandom_range(0, 1));
        sh_dout       = $urandom;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1; r0_req = 0; r1_req = 0; r0_din_valid = 0; r1_din_valid = 0;
    r0_force_done = 0; r1_force_done = 0;
    tick(2);
    rst = 0;
  endtask

  initial begin
    int n, guard, first_g, n_force;
    do_reset();

    // Single requester: grant one cycle after request, 8 words through.
    @(negedge clk);
    chk("rst_r0_gnt", r0_gnt, 0); chk("rst_busy", busy, 0); chk("rst_force", sh_force_done, 0);
    tick();
    r0_req = 1;
    @(negedge clk); chk("a_gnt_not_yet", r0_gnt, 0);
    tick();
    @(negedge clk); chk("a_r0_gnt", r0_gnt, 1); chk("a_r1_gnt", r1_gnt, 0);
    n = 0; guard = 0;
    r0_din_valid = 1;
    while (n < 8 && guard < 200) begin
      r0_din = $urandom;
      @(negedge clk);
      if (sh_din_ready) n++;
      tick(); guard++;
    end
    chk("a_words_sent", n, 8);
    r0_din_valid = 0;

    // Tie after reset goes to r0; r1 follows after flush + idle decision.
    do_reset();
    r0_req = 1; r1_req = 1;
    tick();
    @(negedge clk); chk("b_tie_r0", r0_gnt, 1); chk("b_tie_r1", r1_gnt, 0);
    tick(3);
    r0_req = 0;
    first_g = 0; n_force = 0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      @(negedge clk);
      if (sh_force_done) n_force++;
      if (i <= 2) chk("b_force_hi", sh_force_done, 1);
      if (r1_gnt && first_g == 0) first_g = i;
    end
    chk("b_force_cycles", n_force, 2);
    chk("b_r1_gnt_cycle", first_g, 4);

    // During GRANT1, r0 traffic is ignored.
    tick();
    hold_core = 1; sh_din_ready = 1;
    r0_din_valid = 1; r0_din = 32'hDEADBEEF; r1_din_valid = 0;
    @(negedge clk);
    chk("c_sh_valid_r1only", sh_din_valid, 0); chk("c_r0_ready", r0_din_ready, 0);
    chk("c_r1_ready", r1_din_ready, 1);
    tick();
    r1_din_valid = 1; r1_din = 32'h12345678;
    @(negedge clk);
    chk("c_sh_valid", sh_din_valid, 1); chk("c_sh_din", sh_din, 32'h12345678);
    chk("c_r0_ready2", r0_din_ready, 0);
    tick();
    r0_din_valid = 0; r1_din_valid = 0; hold_core = 0;

    // Tie after r1's session goes to r0; r0 alone then regains the core.
    r1_req = 0;
    tick(FC + 1);
    r0_req = 1; r1_req = 1;
    tick();
    @(negedge clk); chk("d_tie_r0", r0_gnt, 1); chk("d_tie_r1", r1_gnt, 0);
    tick();
    r0_req = 0; r1_req = 0;
    tick(FC + 1);
    r0_req = 1;
    tick();
    @(negedge clk); chk("d_r0_again", r0_gnt, 1);

    // Reset mid-session: straight to idle, no flush pulse.
    r0_dout_ready = 1;
    tick(3);
    rst = 1;
    tick();
    @(negedge clk);
    chk("e_gnt0", r0_gnt, 0); chk("e_gnt1", r1_gnt, 0);
    chk("e_force", sh_force_done, 0); chk("e_busy", busy, 0);
    rst = 0; r0_req = 0;
    tick();
    @(negedge clk); chk("e_no_flush", sh_force_done, 0); chk("e_idle_busy", busy, 0);
    tick();

`ifdef SHAKE_ARB_PERF_EN
    do_reset();
    r0_req = 1; tick(); tick(49); r0_req = 0; tick();
    tick(FC);
    r1_req = 1; tick(); tick(29); r1_req = 0; tick();
    @(negedge clk);
    chk("p_r0_busy", r0_busy_cycles, 50);
    chk("p_r1_busy", r1_busy_cycles, 30);
    chk("p_grants", grant_count, 2);
    tick();
`endif

    // Random sessions, traffic, aborts and occasional resets.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) r0_req = ~r0_req;
      if ($urandom_range(0, 7) == 0) r1_req = ~r1_req;
      r0_din_valid  = 1'($urandom_range(0, 1));
      r1_din_valid  = 1'($urandom_range(0, 1));
      r0_din        = $urandom;
      r1_din        = $urandom;
      r0_dout_ready = 1'($urandom_range(0, 1));
      r1_dout_ready = 1'($urandom_range(0, 1));
      r0_force_done = ($urandom_range(0, 15) == 0);
      r1_force_done = ($urandom_range(0, 15) == 0);
      rst           = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 0; r0_din_valid = 0; r1_din_valid = 0;
    tick(2);
    @(negedge clk);
    chk("q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
